// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO for the MIPS datapath.
// Operands are latched at acceptance; HI/LO update after a fixed busy window.
module mult_div_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] S1,
    input  logic [WIDTH-1:0] S2,
    input  logic [2:0]       MDOp,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned MSB     = WIDTH - 1;
    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             busy_d, done_d;
    logic [WIDTH-1:0] hi_d, lo_d;

    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] mag_a, mag_b, uq, ur, q, r, res_hi, res_lo;
    logic             div_signed, is_div;
    logic             start_md;
    logic [CW-1:0]    load_cnt;

    // Result datapath from latched operands; signed divide via magnitudes
    always_comb begin
        div_signed = (op_q == OP_DIV);
        is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
        mag_a = (div_signed && a_q[MSB]) ? (~a_q + WIDTH'(1)) : a_q;
        mag_b = (div_signed && b_q[MSB]) ? (~b_q + WIDTH'(1)) : b_q;
        if (b_q == '0) begin
            mag_b = WIDTH'(1);
        end
        uq = mag_a / mag_b;
        ur = mag_a % mag_b;
        q  = (div_signed && (a_q[MSB] ^ b_q[MSB])) ? (~uq + WIDTH'(1)) : uq;
        r  = (div_signed && a_q[MSB]) ? (~ur + WIDTH'(1)) : ur;
        if (op_q == OP_MULT) begin
            prod = {{WIDTH{a_q[MSB]}}, a_q} * {{WIDTH{b_q[MSB]}}, b_q};
        end else begin
            prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        end
        if (is_div) begin
            if (b_q == '0) begin
                res_hi = a_q;
                res_lo = '1;
            end else begin
                res_hi = r;
                res_lo = q;
            end
        end else begin
            res_hi = prod[PW-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    assign start_md = Start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    assign load_cnt = (MDOp >= OP_DIV) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = HI;
        lo_d    = LO;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_md) begin
                    state_d = RUN;
                    count_d = load_cnt;
                    a_d     = S1;
                    b_d     = S2;
                    op_d    = MDOp;
                end else if (Start && MDOp == OP_MTHI) begin
                    hi_d = S1;
                end else if (Start && MDOp == OP_MTLO) begin
                    lo_d = S1;
                end
            end
            RUN: begin
                if (count_q == CW'(1)) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                    state_d = IDLE;
                    count_d = '0;
                    // Back-to-back acceptance at the completion edge
                    if (start_md) begin
                        state_d = RUN;
                        count_d = load_cnt;
                        a_d     = S1;
                        b_d     = S2;
                        op_d    = MDOp;
                    end
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            Busy    <= busy_d;
            Done    <= done_d;
            HI      <= hi_d;
            LO      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed spec cases plus random ops
// against a longint-arithmetic reference model.
module tb_mult_div_unit;

    localparam int unsigned W  = 32;
    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] S1, S2;
    logic [2:0]   MDOp;
    logic         Start;
    logic         Busy, Done;
    logic [W-1:0] HI, LO;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_hi, exp_lo;

    mult_div_unit #(.WIDTH(W), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk(clk), .reset(reset), .S1(S1), .S2(S2), .MDOp(MDOp),
        .Start(Start), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {HI, LO} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned up;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            3'd1: begin sq = sa * sb; res = sq; end
            3'd2: begin up = {32'b0, a} * {32'b0, b}; res = up; end
            3'd3: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            3'd4: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = {exp_hi, exp_lo};
        endcase
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an MD op so it is accepted at the next edge; return just after it
    task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; MDOp = op; S1 = a; S2 = b;
        tick();
        Start = 1'b0;
    endtask

    // Walk the busy window from just after acceptance; optional ignored
    // Start at iteration inj_at and optional chained op at the completion edge
    task automatic finish_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit chained_in, input int inj_at, input logic [2:0] inj_op,
                             input bit chain, input logic [2:0] cop, input logic [W-1:0] ca,
                             input logic [W-1:0] cb);
        int unsigned n;
        logic [63:0] r;
        n = (op >= 3'd3) ? ND : NM;
        for (int i = 0; i < int'(n); i++) begin
            chk1("busy_window", Busy, 1'b1);
            chk1("done_low_in_run", Done, (i == 0) ? chained_in : 1'b0);
            chk32("hi_stale", HI, exp_hi);
            chk32("lo_stale", LO, exp_lo);
            S1 = $urandom; S2 = $urandom;
            if (i == inj_at) begin
                Start = 1'b1; MDOp = inj_op; S1 = 32'h55;
            end
            if (chain && i == int'(n) - 1) begin
                Start = 1'b1; MDOp = cop; S1 = ca; S2 = cb;
            end
            tick();
            Start = 1'b0;
        end
        r = ref_md(op, a, b);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        chk1("done_pulse", Done, 1'b1);
        chk1("busy_after", Busy, chain);
        chk32("hi_result", HI, exp_hi);
        chk32("lo_result", LO, exp_lo);
        if (!chain) begin
            tick();
            chk1("done_drop", Done, 1'b0);
            chk1("busy_idle", Busy, 1'b0);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(op, a, b);
        finish_op(op, a, b, 1'b0, -1, 3'd0, 1'b0, 3'd0, '0, '0);
    endtask

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        reset = 1'b1; Start = 1'b0; MDOp = '0; S1 = '0; S2 = '0;
        exp_hi = '0; exp_lo = '0;
        tick(); tick();
        reset = 1'b0;
        chk1("rst_busy", Busy, 1'b0);
        chk1("rst_done", Done, 1'b0);
        chk32("rst_hi", HI, '0);
        chk32("rst_lo", LO, '0);

        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk32("mult_hi_const", HI, 32'hFFFF_FFFF);
        chk32("mult_lo_const", LO, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        chk32("multu_hi_const", HI, 32'h0000_0001);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk32("div_lo_const", LO, 32'hFFFF_FFFD);
        run_op(3'd4, 32'd7, 32'd0);
        chk32("divu0_hi_const", HI, 32'd7);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk32("divovf_lo_const", LO, 32'h8000_0000);
        run_op(3'd3, 32'hFFFF_FF00, 32'd0);

        // MTHI during a DIVU is ignored
        start_op(3'd4, 32'd100, 32'd7);
        finish_op(3'd4, 32'd100, 32'd7, 1'b0, 2, 3'd5, 1'b0, 3'd0, '0, '0);
        chk32("divu_hi_const", HI, 32'd2);
        chk32("divu_lo_const", LO, 32'd14);
        // New MULT while busy is also ignored
        start_op(3'd2, 32'd9, 32'd9);
        finish_op(3'd2, 32'd9, 32'd9, 1'b0, 1, 3'd1, 1'b0, 3'd0, '0, '0);

        // Reset mid-operation aborts without a write, then MTLO lands
        start_op(3'd1, 32'd1234, 32'd5678);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        chk1("abort_busy", Busy, 1'b0);
        chk1("abort_done", Done, 1'b0);
        chk32("abort_hi", HI, '0);
        chk32("abort_lo", LO, '0);
        Start = 1'b1; MDOp = 3'd6; S1 = 32'h1234;
        tick();
        Start = 1'b0;
        exp_lo = 32'h1234;
        chk32("mtlo_lo", LO, exp_lo);
        chk32("mtlo_hi", HI, exp_hi);
        chk1("mtlo_busy", Busy, 1'b0);
        chk1("mtlo_done", Done, 1'b0);
        Start = 1'b1; MDOp = 3'd5; S1 = 32'hCAFE_F00D;
        tick();
        Start = 1'b0;
        exp_hi = 32'hCAFE_F00D;
        chk32("mthi_hi", HI, exp_hi);
        chk1("mthi_done", Done, 1'b0);

        // MDOp 0 and 7 have no effect
        Start = 1'b1; MDOp = 3'd0; S1 = 32'hDEAD_BEEF;
        tick();
        MDOp = 3'd7;
        tick();
        Start = 1'b0;
        chk1("nop_busy", Busy, 1'b0);
        chk32("nop_hi", HI, exp_hi);
        chk32("nop_lo", LO, exp_lo);

        // Back-to-back MULTU
        start_op(3'd2, 32'h0001_0000, 32'h0003_0000);
        finish_op(3'd2, 32'h0001_0000, 32'h0003_0000, 1'b0, -1, 3'd0,
                  1'b1, 3'd2, 32'hFFFF_0001, 32'h1234_5678);
        finish_op(3'd2, 32'hFFFF_0001, 32'h1234_5678, 1'b1, -1, 3'd0, 1'b0, 3'd0, '0, '0);

        // Random ops with occasional zero divisors and INT_MIN operands
        for (int k = 0; k < 30; k++) begin
            op = 3'(1 + ($urandom % 4));
            a  = $urandom;
            b  = $urandom;
            if ($urandom % 8 == 0) b = '0;
            if ($urandom % 8 == 0) a = 32'h8000_0000;
            if ($urandom % 8 == 0) b = 32'hFFFF_FFFF;
            if ($urandom % 4 == 0) b = 32'($urandom % 16);
            run_op(op, a, b);
            if ($urandom % 3 == 0) begin
                a = $urandom;
                Start = 1'b1; MDOp = 3'(5 + ($urandom % 2)); S1 = a;
                if (MDOp == 3'd5) exp_hi = a; else exp_lo = a;
                tick();
                Start = 1'b0;
                chk32("rand_mt_hi", HI, exp_hi);
                chk32("rand_mt_lo", LO, exp_lo);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
